// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: line, configuration and parity-checker/consumer signals
// of the UART RX frame controller, bundled into one interface.
//   master : bench/system side; drives RX_IN, PAR_EN, PAR_TYP, Prescale and
//            par_err, and observes the controller outputs.
//   slave  : the frame controller itself.
// Optional macro UART_RX_FRAME_STATS_EN adds frame_cnt / err_cnt.
interface uart_rx_frame_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESC_W-1:0]    Prescale;
  logic                  par_err;
  logic [DATA_WIDTH-1:0] P_data;
  logic                  sampled_bit;
  logic                  parity_check_en;
  logic                  par_typ_q;
  logic                  data_valid;
  logic                  par_err_q;
  logic                  stop_err;
  logic                  start_glitch;
`ifdef UART_RX_FRAME_STATS_EN
  logic [15:0]           frame_cnt;
  logic [15:0]           err_cnt;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale, par_err,
    input  P_data, sampled_bit, parity_check_en, par_typ_q, data_valid,
           par_err_q, stop_err, start_glitch, frame_cnt, err_cnt
  );
  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale, par_err,
    output P_data, sampled_bit, parity_check_en, par_typ_q, data_valid,
           par_err_q, stop_err, start_glitch, frame_cnt, err_cnt
  );
`else
  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale, par_err,
    input  P_data, sampled_bit, parity_check_en, par_typ_q, data_valid,
           par_err_q, stop_err, start_glitch
  );
  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale, par_err,
    output P_data, sampled_bit, parity_check_en, par_typ_q, data_valid,
           par_err_q, stop_err, start_glitch
  );
`endif
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART receiver front end. Counts oversampling edges,
// majority-votes three mid-bit samples, deserialises LSB first and sequences
// START/DATA/PARITY/STOP. Drives the external parity checker and reports
// data_valid, parity/stop error flags and false-start pulses.
// Ports:
//   clk  : oversampling clock
//   rst  : synchronous active-low reset
//   bus  : uart_rx_frame_ctrl_if.slave
//          in : RX_IN, PAR_EN, PAR_TYP, Prescale (8/16/32, else 8), par_err
//          out: P_data, sampled_bit, parity_check_en, par_typ_q, data_valid,
//               par_err_q, stop_err, start_glitch
// Optional macro UART_RX_FRAME_STATS_EN adds saturating frame_cnt / err_cnt.
module uart_rx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_rx_frame_ctrl_if.slave  bus
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [PRESC_W-1:0]   P_DEF    = PRESC_W'(8);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q, state_d;
  logic [PRESC_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [2:0]            samp_q, samp_d;
  logic                  sampled_bit_q, sampled_bit_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  parity_check_en_q, parity_check_en_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;
  logic                  start_glitch_q, start_glitch_d;
`ifdef UART_RX_FRAME_STATS_EN
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
`endif

  logic [PRESC_W-1:0]    half;
  logic                  last_edge;
  logic                  presc_legal;

  // Next-state, counters, sampling and output strobes
  always_comb begin
    state_d           = state_q;
    edge_cnt_d        = edge_cnt_q;
    bit_cnt_d         = bit_cnt_q;
    presc_d           = presc_q;
    par_en_d          = par_en_q;
    par_typ_d         = par_typ_q;
    samp_d            = samp_q;
    sampled_bit_d     = sampled_bit_q;
    p_data_d          = p_data_q;
    parity_check_en_d = 1'b0;
    data_valid_d      = 1'b0;
    par_err_d         = par_err_q;
    stop_err_d        = stop_err_q;
    start_glitch_d    = 1'b0;
`ifdef UART_RX_FRAME_STATS_EN
    frame_cnt_d       = frame_cnt_q;
    err_cnt_d         = err_cnt_q;
`endif

    half        = presc_q >> 1;
    last_edge   = (edge_cnt_q == presc_q - PRESC_W'(1));
    presc_legal = (bus.Prescale == PRESC_W'(8))  ||
                  (bus.Prescale == PRESC_W'(16)) ||
                  (bus.Prescale == PRESC_W'(32));

    // Bit-period counter and mid-bit majority sampling while in a frame
    if (state_q != IDLE) begin
      edge_cnt_d = last_edge ? '0 : edge_cnt_q + PRESC_W'(1);
      if ((edge_cnt_q == half - PRESC_W'(1)) || (edge_cnt_q == half) ||
          (edge_cnt_q == half + PRESC_W'(1))) begin
        samp_d = {samp_q[1:0], bus.RX_IN};
      end
      if (edge_cnt_q == half + PRESC_W'(2)) begin
        sampled_bit_d = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                        (samp_q[1] & samp_q[2]);
      end
    end

    unique case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        // Start-detect cycle counts as edge 0 of the start bit
        if (!bus.RX_IN) begin
          state_d    = START;
          edge_cnt_d = PRESC_W'(1);
          presc_d    = presc_legal ? bus.Prescale : P_DEF;
          par_en_d   = bus.PAR_EN;
          par_typ_d  = bus.PAR_TYP;
        end
      end
      START: begin
        if (last_edge) begin
          if (sampled_bit_q) begin
            start_glitch_d = 1'b1;
            state_d        = IDLE;
`ifdef UART_RX_FRAME_STATS_EN
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
`endif
          end else begin
            par_err_d  = 1'b0;
            stop_err_d = 1'b0;
            bit_cnt_d  = '0;
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        if (last_edge) begin
          p_data_d = DATA_WIDTH'({sampled_bit_q, p_data_q} >> 1);
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      PARITY: begin
        // Strobe is raised one cycle early so the registered output lands on edge P-1
        if (edge_cnt_q == presc_q - PRESC_W'(2)) parity_check_en_d = 1'b1;
        if (last_edge) begin
          par_err_d = bus.par_err;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (last_edge) begin
          stop_err_d   = ~sampled_bit_q;
          data_valid_d = ~par_err_q & sampled_bit_q;
          state_d      = IDLE;
`ifdef UART_RX_FRAME_STATS_EN
          if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
          if ((par_err_q | ~sampled_bit_q) && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= IDLE;
      edge_cnt_q        <= '0;
      bit_cnt_q         <= '0;
      presc_q           <= P_DEF;
      par_en_q          <= 1'b0;
      par_typ_q         <= 1'b0;
      samp_q            <= '0;
      sampled_bit_q     <= 1'b1;
      p_data_q          <= '0;
      parity_check_en_q <= 1'b0;
      data_valid_q      <= 1'b0;
      par_err_q         <= 1'b0;
      stop_err_q        <= 1'b0;
      start_glitch_q    <= 1'b0;
`ifdef UART_RX_FRAME_STATS_EN
      frame_cnt_q       <= '0;
      err_cnt_q         <= '0;
`endif
    end else begin
      state_q           <= state_d;
      edge_cnt_q        <= edge_cnt_d;
      bit_cnt_q         <= bit_cnt_d;
      presc_q           <= presc_d;
      par_en_q          <= par_en_d;
      par_typ_q         <= par_typ_d;
      samp_q            <= samp_d;
      sampled_bit_q     <= sampled_bit_d;
      p_data_q          <= p_data_d;
      parity_check_en_q <= parity_check_en_d;
      data_valid_q      <= data_valid_d;
      par_err_q         <= par_err_d;
      stop_err_q        <= stop_err_d;
      start_glitch_q    <= start_glitch_d;
`ifdef UART_RX_FRAME_STATS_EN
      frame_cnt_q       <= frame_cnt_d;
      err_cnt_q         <= err_cnt_d;
`endif
    end
  end

  assign bus.P_data          = p_data_q;
  assign bus.sampled_bit     = sampled_bit_q;
  assign bus.parity_check_en = parity_check_en_q;
  assign bus.par_typ_q       = par_typ_q;
  assign bus.data_valid      = data_valid_q;
  assign bus.par_err_q       = par_err_q;
  assign bus.stop_err        = stop_err_q;
  assign bus.start_glitch    = start_glitch_q;
`ifdef UART_RX_FRAME_STATS_EN
  assign bus.frame_cnt       = frame_cnt_q;
  assign bus.err_cnt         = err_cnt_q;
`endif

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Front end of the UART receiver: oversampled edge counting, 3-sample majority-vote bit sampling, LSB-first deserialisation and frame FSM.
- Drives the downstream parity checker with P_data, sampled_bit, PAR_TYP and a one-cycle parity_check_en.
- Consumes the checker's par_err and produces data_valid plus frame error flags for the RX consumer.

Parameters:
- DATA_WIDTH, 8, data bits per frame (LSB first).
- PRESC_W, 6, width of Prescale input.

Ports:
- clk  in  1  system clock (oversampling clock).
- rst  in  1  synchronous, active-low reset.
- RX_IN  in  1  serial line, idle high.
- PAR_EN  in  1  parity bit present when 1.
- PAR_TYP  in  1  0 = even, 1 = odd; forwarded as par_typ_q.
- Prescale  in  PRESC_W  oversampling ratio; legal values 8, 16, 32.
- par_err  in  1  from parity checker; valid only while parity_check_en = 1.
- P_data  out  DATA_WIDTH  deserialised byte.
- sampled_bit  out  1  majority-voted current bit.
- parity_check_en  out  1  one-cycle parity check strobe.
- par_typ_q  out  1  PAR_TYP latched at frame start.
- data_valid  out  1  one-cycle pulse, frame good.
- par_err_q  out  1  latched parity error of last frame.
- stop_err  out  1  stop bit sampled 0 in last frame.
- start_glitch  out  1  one-cycle pulse, false start.

Behaviour:
- Reset values: P_data 0, sampled_bit 1, parity_check_en 0, par_typ_q 0, data_valid 0, par_err_q 0, stop_err 0, start_glitch 0, state IDLE, edge_cnt 0, bit_cnt 0.
- Reset mid-frame aborts the frame: no data_valid, no error pulse.
- Config latch: on start detect, PAR_EN, PAR_TYP and Prescale are latched (P). Later changes are ignored until the next frame.
  - Prescale not in {8, 16, 32} is latched as 8.
- Edge counter: 0..P-1 per bit; wraps to 0 at P-1, advancing bit position.
- Sampling: RX_IN captured at edge_cnt = P/2-1, P/2, P/2+1. The majority is registered into sampled_bit at edge_cnt = P/2+2. sampled_bit holds otherwise.
- Timing reference: the cycle in which IDLE sees RX_IN = 0 is cycle 0, with edge_cnt = 0 for the start bit.
- States:
  - IDLE: wait for RX_IN = 0 -> START.
  - START: at edge_cnt = P-1, if sampled_bit = 1, pulse start_glitch and go to IDLE; else clear par_err_q and stop_err, then go to DATA.
  - DATA: at each edge_cnt = P-1, shift right with P_data[MSB] <= sampled_bit. After DATA_WIDTH bits go to PARITY if PAR_EN, else STOP.
  - PARITY: at edge_cnt = P-1, assert parity_check_en for exactly that cycle and register par_err into par_err_q; -> STOP.
  - STOP: at edge_cnt = P-1, stop_err <= ~sampled_bit. Pulse data_valid in the next cycle iff the parity error and the new stop error are both 0. -> IDLE.
- data_valid timing: cycle (1+DATA_WIDTH+PAR_EN+1)*P. Example: P = 8, PAR_EN = 1 gives cycle 88.
- Line low in IDLE on the data_valid cycle is a new start detect; no cycle is lost.
- P_data changes only on DATA shifts and is stable from the last data shift through the next frame's first data shift.
- parity_check_en is never asserted when PAR_EN = 0. par_err is ignored outside the strobe.
- par_err_q and stop_err hold until the next valid start bit.

Optional Feature:
- Macro: UART_RX_FRAME_STATS_EN.
- When defined, adds outputs frame_cnt[15:0] and err_cnt[15:0], both saturating at 16'hFFFF and reset to 0.
  - frame_cnt increments on every completed frame (STOP exit).
  - err_cnt increments on completed frames with a parity or stop error, and on start_glitch.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- P = 8, PAR_EN = 0, send 0xA5 with good stop -> P_data = 0xA5, data_valid pulse at cycle 80, stop_err = 0, parity_check_en never high.
- P = 16, PAR_EN = 1, PAR_TYP = 0, send 0x3C with parity 0 -> one parity_check_en pulse at cycle 159; with par_err = 0 from the model, data_valid at cycle 176.
- Same frame with wrong parity bit (par_err = 1 at strobe) -> no data_valid, par_err_q = 1 until next valid start.
- P = 8, RX_IN low for 3 cycles then high -> start_glitch pulse at cycle 8, return to IDLE, P_data unchanged.
- P = 32, send 0x00 with stop bit 0 -> stop_err = 1, no data_valid. Next good frame 0xFF -> stop_err cleared at end of start bit, data_valid asserted.
- rst low during DATA bit 4 of a frame -> all outputs at reset values next cycle. A following 0x5A frame is received correctly. Prescale = 12 is latched as 8.
